decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_if.sv | 22 ++
 rtl/decode.sv | 74 +++++++
 tb/tb_decode.sv | 109 ++++++++++
 3 files changed

// File: rtl/decode_if.sv
// decode_if: instruction, writeback and decoded-output signals of the decode stage.
interface decode_if;
    logic [31:0] instr;
    logic        in_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  write_dest;
    logic [31:0] read_reg_1;
    logic [31:0] read_reg_2;
    logic [1:0]  alu_op;
    logic        out_valid;
    logic        illegal;
    modport master (
        output instr, in_valid, wb_en, wb_addr, wb_data,
        input  write_dest, read_reg_1, read_reg_2, alu_op, out_valid, illegal
    );
    modport slave (
        input  instr, in_valid, wb_en, wb_addr, wb_data,
        output write_dest, read_reg_1, read_reg_2, alu_op, out_valid, illegal
    );
endinterface

// File: rtl/decode.sv
// decode: one-cycle R-type decoder over a 32x32 register file.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback to the read ports.
module decode (
    input logic     clk,
    input logic     rst,
    decode_if.slave bus
);
    logic [31:0] r_rf [32];
    logic [4:0]  r_write_dest;
    logic [31:0] r_read_reg_1;
    logic [31:0] r_read_reg_2;
    logic [1:0]  r_alu_op;
    logic        r_out_valid;
    logic        r_illegal;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_legal;
    logic        w_wb;
    logic [1:0]  w_alu_op;
    logic [31:0] w_rf1;
    logic [31:0] w_rf2;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];
    assign w_rs    = bus.instr[25:21];
    assign w_rt    = bus.instr[20:16];
    assign w_legal = w_op == 6'd0 && (w_funct == 6'h20 || w_funct == 6'h22 ||
                                      w_funct == 6'h24 || w_funct == 6'h25);
    assign w_alu_op = !w_legal ? 2'b00 :
                      w_funct == 6'h22 ? 2'b01 :
                      w_funct == 6'h24 ? 2'b10 :
                      w_funct == 6'h25 ? 2'b11 : 2'b00;
    assign w_wb  = bus.wb_en && bus.wb_addr != 5'd0;
    // Register 0 is decoded as constant zero; its storage is never written.
    assign w_rf1 = w_rs == 5'd0 ? 32'd0 : r_rf[w_rs];
    assign w_rf2 = w_rt == 5'd0 ? 32'd0 : r_rf[w_rt];
`ifdef DECODE_WB_BYPASS_EN
    assign w_rd1 = w_wb && bus.wb_addr == w_rs ? bus.wb_data : w_rf1;
    assign w_rd2 = w_wb && bus.wb_addr == w_rt ? bus.wb_data : w_rf2;
`else
    assign w_rd1 = w_rf1;
    assign w_rd2 = w_rf2;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
            r_write_dest <= '0;
            r_read_reg_1 <= '0;
            r_read_reg_2 <= '0;
            r_alu_op     <= '0;
            r_out_valid  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_wb) r_rf[bus.wb_addr] <= bus.wb_data;
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_write_dest <= w_legal ? bus.instr[15:11] : 5'd0;
                r_read_reg_1 <= w_rd1;
                r_read_reg_2 <= w_rd2;
                r_alu_op     <= w_alu_op;
                r_illegal    <= !w_legal;
            end
        end
    end
    assign bus.write_dest = r_write_dest;
    assign bus.read_reg_1 = r_read_reg_1;
    assign bus.read_reg_2 = r_read_reg_2;
    assign bus.alu_op     = r_alu_op;
    assign bus.out_valid  = r_out_valid;
    assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed vectors for decode; expected results queued at issue, checked by a monitor.
module tb_decode;
    typedef struct packed {
        logic [4:0]  wd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [1:0]  op;
        logic        ill;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];
    decode_if bus ();
    decode dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic cyc(input logic [31:0] ins, input logic v, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wdat);
        bus.instr = ins; bus.in_valid = v; bus.wb_en = wen; bus.wb_addr = wa; bus.wb_data = wdat;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    endtask
    task automatic issue(input logic [31:0] ins, input exp_t e);
        q.push_back(e);
        cyc(ins, 1'b1, 1'b0, 5'd0, 32'd0);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_wd"}, {27'd0, bus.write_dest}, 32'd0);
        check({tag, "_r1"}, bus.read_reg_1, 32'd0);
        check({tag, "_r2"}, bus.read_reg_2, 32'd0);
        check({tag, "_op"}, {30'd0, bus.alu_op}, 32'd0);
        check({tag, "_ov"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ill"}, {31'd0, bus.illegal}, 32'd0);
    endtask
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            exp_t e;
            exp_t a;
            a = '{bus.write_dest, bus.read_reg_1, bus.read_reg_2, bus.alu_op, bus.illegal};
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got %h with empty queue", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL decode_out: got wd=%0d r1=%h r2=%h op=%b ill=%b expected wd=%0d r1=%h r2=%h op=%b ill=%b",
                             a.wd, a.r1, a.r2, a.op, a.ill, e.wd, e.r1, e.r2, e.op, e.ill);
                end
            end
        end
    end
    initial begin
        bus.instr = '0; bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        rst = 1'b1;
        cyc(32'h00221820, 1'b1, 1'b1, 5'd5, 32'h55);
        cyc(32'h00221820, 1'b1, 1'b1, 5'd5, 32'h55);
        check_zero("reset");
        rst = 1'b0;
        issue(32'h00221820, '{5'd3, 32'd0, 32'd0, 2'b00, 1'b0});
        cyc(32'd0, 1'b0, 1'b1, 5'd1, 32'd5);
        check("hold_wd", {27'd0, bus.write_dest}, 32'd3);
        check("hold_ov", {31'd0, bus.out_valid}, 32'd0);
        cyc(32'd0, 1'b0, 1'b1, 5'd2, 32'd7);
        issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 6'h20), '{5'd3, 32'd5, 32'd7, 2'b00, 1'b0});
        issue(mk(6'd0, 5'd1, 5'd2, 5'd4, 6'h22), '{5'd4, 32'd5, 32'd7, 2'b01, 1'b0});
        issue(mk(6'd0, 5'd1, 5'd2, 5'd5, 6'h24), '{5'd5, 32'd5, 32'd7, 2'b10, 1'b0});
        issue(mk(6'd0, 5'd1, 5'd2, 5'd6, 6'h25), '{5'd6, 32'd5, 32'd7, 2'b11, 1'b0});
        issue(mk(6'h08, 5'd1, 5'd2, 5'd7, 6'h20), '{5'd0, 32'd5, 32'd7, 2'b00, 1'b1});
        issue(mk(6'd0, 5'd2, 5'd1, 5'd7, 6'h21), '{5'd0, 32'd7, 32'd5, 2'b00, 1'b1});
        cyc(32'd0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("hold_ill", {31'd0, bus.illegal}, 32'd1);
        issue(mk(6'd0, 5'd0, 5'd0, 5'd1, 6'h20), '{5'd1, 32'd0, 32'd0, 2'b00, 1'b0});
        issue(mk(6'd0, 5'd2, 5'd2, 5'd8, 6'h24), '{5'd8, 32'd7, 32'd7, 2'b10, 1'b0});
`ifdef DECODE_WB_BYPASS_EN
        q.push_back('{5'd9, 32'd9, 32'd0, 2'b00, 1'b0});
`else
        q.push_back('{5'd9, 32'd0, 32'd0, 2'b00, 1'b0});
`endif
        cyc(mk(6'd0, 5'd4, 5'd0, 5'd9, 6'h20), 1'b1, 1'b1, 5'd4, 32'd9);
        issue(mk(6'd0, 5'd4, 5'd1, 5'd10, 6'h25), '{5'd10, 32'd9, 32'd5, 2'b11, 1'b0});
        cyc(32'd0, 1'b0, 1'b1, 5'd6, 32'h66);
        issue(mk(6'd0, 5'd6, 5'd1, 5'd11, 6'h20), '{5'd11, 32'h66, 32'd5, 2'b00, 1'b0});
        rst = 1'b1;
        cyc(mk(6'd0, 5'd6, 5'd1, 5'd12, 6'h22), 1'b1, 1'b1, 5'd6, 32'h77);
        rst = 1'b0;
        check_zero("midrst");
        issue(mk(6'd0, 5'd6, 5'd1, 5'd13, 6'h22), '{5'd13, 32'd0, 32'd0, 2'b01, 1'b0});
        cyc(32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cyc(32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
